// File: rtl/fifo_uart_tx_if.sv
// Fifo read port plus UART line status for the fifo-to-UART transmitter.
// master = transmitter side, slave = fifo / line side.
interface fifo_uart_tx_if;
    logic       empty;
    logic [7:0] fifo_data;
    logic       pop;
    logic       tx;
    logic       busy;
    logic       sent;

    modport master (
        input  empty,
        input  fifo_data,
        output pop,
        output tx,
        output busy,
        output sent
    );

    modport slave (
        output empty,
        output fifo_data,
        input  pop,
        input  tx,
        input  busy,
        input  sent
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a fifo and serialises each as an 8N1/8N2 UART frame on tx.
// Latency: start bit begins 2 cycles after pop; frame lasts (9+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpressure: pops only from IDLE while empty is low; one byte in flight at a time.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          pop_q;
    logic          tx_q;
    logic          busy_q;
    logic          sent_q;

    assign bus.pop  = pop_q;
    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.sent = sent_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            pop_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
        end else begin
            pop_q  <= 1'b0;
            sent_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (!bus.empty) begin
                        state  <= S_POP;
                        pop_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_POP: begin
                    state <= S_WAIT;
                end
                // fifo_data settled during POP; this is the only point it is sampled.
                S_WAIT: begin
                    shreg    <= bus.fifo_data;
                    state    <= S_START;
                    tx_q     <= 1'b0;
                    baud_cnt <= '0;
                end
                S_START: begin
                    if (baud_cnt == CNT_LAST) begin
                        state    <= S_DATA;
                        tx_q     <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= S_STOP;
                            tx_q    <= 1'b1;
                            bit_idx <= '0;
                        end else begin
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                // bit_idx counts stop bits here; sent is raised one cycle early so
                // the registered pulse lands on the final stop cycle.
                S_STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            state   <= S_IDLE;
                            busy_q  <= 1'b0;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        sent_q   <= (bit_idx == STOP_LAST) && (baud_cnt == CNT_PEN);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance with 1 stop bit, one with 2,
// both at 4 clocks per bit; outputs checked every cycle as {pop,tx,busy,sent}.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fifo_uart_tx_if bus1();
    fifo_uart_tx_if bus2();

    fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs(input int d);
        if (d == 2) return {bus2.pop, bus2.tx, bus2.busy, bus2.sent};
        return {bus1.pop, bus1.tx, bus1.busy, bus1.sent};
    endfunction

    task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s pop/tx/busy/sent=%b expected %b", tag, o, e);
        end
    endtask

    task automatic drive(input int d, input logic e, input logic [7:0] v);
        if (d == 2) begin
            bus2.empty     = e;
            bus2.fifo_data = v;
        end else begin
            bus1.empty     = e;
            bus1.fifo_data = v;
        end
    endtask

    // Caller leaves the DUT in IDLE with empty low. The fifo model presents the
    // popped byte only after pop is seen, then raises empty unless more bytes remain.
    task automatic frame(input int d, input string tag, input logic [7:0] b,
                         input int stops, input logic more, input logic disturb);
        int   len;
        logic exp_tx;
        len = (9 + stops) * 4;
        tick();
        chk({tag, "_pop"}, outs(d), 4'b1110);
        drive(d, !more, b);
        tick();
        chk({tag, "_wait"}, outs(d), 4'b0110);
        tick();
        for (int i = 0; i < len; i++) begin
            if (i > 0) tick();
            if (i < 4)       exp_tx = 1'b0;
            else if (i < 36) exp_tx = b[(i - 4) / 4];
            else             exp_tx = 1'b1;
            chk($sformatf("%s_c%0d", tag, i), outs(d), {1'b0, exp_tx, 1'b1, i == len - 1});
            if (disturb && i >= 4 && i < 34)
                drive(d, ($urandom_range(0, 1) == 1), 8'($urandom));
            if (disturb && i == 34)
                drive(d, !more, b);
        end
        tick();
        chk({tag, "_idle"}, outs(d), 4'b0100);
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 1'b1, 8'h00);
        drive(2, 1'b1, 8'h00);
        tick();
        tick();
        chk("rst1", outs(1), 4'b0100);
        chk("rst2", outs(2), 4'b0100);
        reset = 1'b0;

        // idle with empty fifo
        for (int i = 0; i < 100; i++) begin
            tick();
            chk($sformatf("idle_c%0d", i), outs(1), 4'b0100);
        end

        // single byte 0xA5
        drive(1, 1'b0, 8'h00);
        frame(1, "a5", 8'hA5, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("a5_after%0d", i), outs(1), 4'b0100);
        end

        // three bytes back to back, 3-cycle tx-high gap between frames
        drive(1, 1'b0, 8'h00);
        frame(1, "b0", 8'h00, 1, 1'b1, 1'b0);
        frame(1, "b1", 8'hFF, 1, 1'b1, 1'b0);
        frame(1, "b2", 8'h3C, 1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("b_after%0d", i), outs(1), 4'b0100);
        end

        // two stop bits, byte 0x80, 44-cycle frame
        drive(2, 1'b0, 8'h00);
        frame(2, "s2", 8'h80, 2, 1'b0, 1'b0);
        tick();
        chk("s2_after", outs(2), 4'b0100);

        // reset in the middle of data bit 3 (byte 0x07, bit3 = 0)
        drive(1, 1'b0, 8'h00);
        tick();
        chk("mr_pop", outs(1), 4'b1110);
        drive(1, 1'b1, 8'h07);
        tick();
        chk("mr_wait", outs(1), 4'b0110);
        tick();
        for (int i = 0; i < 17; i++) tick();
        chk("mr_bit3", outs(1), 4'b0010);
        reset = 1'b1;
        tick();
        chk("mr_rst", outs(1), 4'b0100);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("mr_quiet%0d", i), outs(1), 4'b0100);
        end
        drive(1, 1'b0, 8'h00);
        frame(1, "mr_next", 8'h5A, 1, 1'b0, 1'b0);

        // inputs toggling during data bits must not disturb the frame
        drive(1, 1'b0, 8'h00);
        frame(1, "tg", 8'hC3, 1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("tg_after%0d", i), outs(1), 4'b0100);
        end
        chk("dut2_idle_end", outs(2), 4'b0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
